// File: rtl/pll_phase_ctrl_dyn.sv
// Dynamic phase controller for a PLL with up to 8 outputs: applies initial
// per-output phase steps after lock, then serves runtime adjust requests.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | waiting for LOCK_WAIT consecutive cycles of raw PLL lock
// INIT_NEXT | scanning outputs for initial step counts, one index/cycle
// SETUP     | phasesel/phasedir presented, no step pulse yet
// PULSE     | phasestep high for PULSE_CYC cycles
// GAP       | phasestep low for GAP_CYC cycles, then next step or return
// IDLE      | init done, accepting runtime requests
module pll_phase_ctrl_dyn #(
  parameter int NUM_OUT = 5,
  parameter int SEL_W = 3,
  parameter int STEP_W = 4,
  parameter logic [NUM_OUT*STEP_W-1:0] INIT_STEPS = '0,
  parameter logic [NUM_OUT-1:0] INIT_EN = '1,
  parameter int LOCK_WAIT = 16,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pll_lock_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [SEL_W-1:0]  req_sel_i,
  input  logic              req_dir_i,
  input  logic [STEP_W-1:0] req_steps_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [SEL_W-1:0]  phasesel_o,
  output logic              phasedir_o,
  output logic              phasestep_o,
  output logic              phaseloadreg_o,
  output logic              busy_o,
  output logic              lock_o,
  output logic              done_pll_init_o
);

  localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int LCNT_W = $clog2(LOCK_WAIT + 1);

  localparam logic [TMR_W-1:0]  TMR_PULSE = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0]  TMR_GAP   = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOCK_WAIT - 1);
  localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);
  localparam logic [3:0]        IDX_END   = 4'(NUM_OUT);
  localparam logic [3:0]        IDX_LAST  = 4'(NUM_OUT - 1);
  localparam logic [3:0]        IDX_ONE   = 4'd1;
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W + 1)'(NUM_OUT);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_INIT_NEXT = 3'd1,
    S_SETUP     = 3'd2,
    S_PULSE     = 3'd3,
    S_GAP       = 3'd4,
    S_IDLE      = 3'd5
  } state_t;

  state_t              r_state;
  logic [LCNT_W-1:0]   r_lock_cnt;
  logic [3:0]          r_idx;
  logic [STEP_W-1:0]   r_steps;
  logic [TMR_W-1:0]    r_tmr;
  logic [SEL_W-1:0]    r_sel;
  logic                r_dir;
  logic                r_done;
  logic                r_in_req;
  logic                r_resp_valid;
  logic                r_resp_err;

  state_t              w_state_nxt;
  logic [LCNT_W-1:0]   w_lock_cnt_nxt;
  logic [3:0]          w_idx_nxt;
  logic [STEP_W-1:0]   w_steps_nxt;
  logic [TMR_W-1:0]    w_tmr_nxt;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic                w_dir_nxt;
  logic                w_done_nxt;
  logic                w_in_req_nxt;
  logic                w_resp_valid_nxt;
  logic                w_resp_err_nxt;

  logic                w_accept;
  logic                w_lock_lost;
  logic                w_sel_bad;
  logic [STEP_W-1:0]   w_init_cnt [8];
  logic [7:0]          w_init_need;

  // Tables are padded to 8 entries so the 3-bit index always lands in range.
  for (genvar k = 0; k < 8; k++) begin : g_init
    if (k < NUM_OUT) begin : g_on
      assign w_init_cnt[k]  = INIT_STEPS[k*STEP_W +: STEP_W];
      assign w_init_need[k] = INIT_EN[k] && (INIT_STEPS[k*STEP_W +: STEP_W] != '0);
    end else begin : g_off
      assign w_init_cnt[k]  = '0;
      assign w_init_need[k] = 1'b0;
    end
  end

  assign w_accept    = req_valid_i & req_ready_o;
  assign w_lock_lost = ~pll_lock_i & (r_state != S_WAIT_LOCK);
  assign w_sel_bad   = {1'b0, req_sel_i} >= SEL_LIMIT;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_WAIT_LOCK;
      r_lock_cnt   <= '0;
      r_idx        <= '0;
      r_steps      <= '0;
      r_tmr        <= '0;
      r_sel        <= '0;
      r_dir        <= 1'b0;
      r_done       <= 1'b0;
      r_in_req     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_steps      <= w_steps_nxt;
      r_tmr        <= w_tmr_nxt;
      r_sel        <= w_sel_nxt;
      r_dir        <= w_dir_nxt;
      r_done       <= w_done_nxt;
      r_in_req     <= w_in_req_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_idx_nxt        = r_idx;
    w_steps_nxt      = r_steps;
    w_tmr_nxt        = r_tmr;
    w_sel_nxt        = r_sel;
    w_dir_nxt        = r_dir;
    w_done_nxt       = r_done;
    w_in_req_nxt     = r_in_req;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;

    case (r_state)
      S_WAIT_LOCK: begin
        if (pll_lock_i) begin
          if (r_lock_cnt == LCNT_LAST) begin
            w_state_nxt    = S_INIT_NEXT;
            w_lock_cnt_nxt = '0;
            w_idx_nxt      = '0;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + LCNT_ONE;
          end
        end else begin
          w_lock_cnt_nxt = '0;
        end
      end

      S_INIT_NEXT: begin
        if (r_idx >= IDX_END) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_init_need[r_idx[2:0]]) begin
          w_steps_nxt  = w_init_cnt[r_idx[2:0]];
          w_sel_nxt    = SEL_W'(r_idx);
          w_dir_nxt    = 1'b0;
          w_in_req_nxt = 1'b0;
          w_idx_nxt    = r_idx + IDX_ONE;
          w_state_nxt  = S_SETUP;
        end else if (r_idx == IDX_LAST) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + IDX_ONE;
        end
      end

      S_SETUP: begin
        w_tmr_nxt   = TMR_PULSE;
        w_state_nxt = S_PULSE;
      end

      S_PULSE: begin
        if (r_tmr == '0) begin
          w_tmr_nxt   = TMR_GAP;
          w_state_nxt = S_GAP;
        end else begin
          w_tmr_nxt = r_tmr - TMR_ONE;
        end
      end

      S_GAP: begin
        if (r_tmr == '0) begin
          w_steps_nxt = r_steps - STEP_ONE;
          if (r_steps != STEP_ONE) begin
            w_tmr_nxt   = TMR_PULSE;
            w_state_nxt = S_PULSE;
          end else if (r_in_req) begin
            w_state_nxt      = S_IDLE;
            w_in_req_nxt     = 1'b0;
            w_resp_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_INIT_NEXT;
          end
        end else begin
          w_tmr_nxt = r_tmr - TMR_ONE;
        end
      end

      S_IDLE: begin
        if (w_accept) begin
          if (w_sel_bad) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else if (req_steps_i == '0) begin
            w_resp_valid_nxt = 1'b1;
          end else begin
            w_sel_nxt    = req_sel_i;
            w_dir_nxt    = req_dir_i;
            w_steps_nxt  = req_steps_i;
            w_in_req_nxt = 1'b1;
            w_state_nxt  = S_SETUP;
          end
        end
      end

      default: w_state_nxt = S_WAIT_LOCK;
    endcase

    // Lock loss overrides everything; any request in hand is reported as aborted.
    if (w_lock_lost) begin
      w_state_nxt      = S_WAIT_LOCK;
      w_lock_cnt_nxt   = '0;
      w_idx_nxt        = '0;
      w_done_nxt       = 1'b0;
      w_in_req_nxt     = 1'b0;
      w_resp_valid_nxt = r_in_req | w_accept;
      w_resp_err_nxt   = r_in_req | w_accept;
    end
  end

  assign req_ready_o     = (r_state == S_IDLE) & r_done;
  assign resp_valid_o    = r_resp_valid;
  assign resp_err_o      = r_resp_err;
  assign phasesel_o      = r_sel;
  assign phasedir_o      = r_dir;
  assign phasestep_o     = (r_state == S_PULSE);
  assign phaseloadreg_o  = 1'b0;
  assign busy_o          = (r_state != S_IDLE) && (r_state != S_WAIT_LOCK);
  assign lock_o          = pll_lock_i & r_done;
  assign done_pll_init_o = r_done;

endmodule

// File: tb/tb_pll_phase_ctrl_dyn.sv
// Scoreboard bench for pll_phase_ctrl_dyn: expected pulses and responses are
// queued at stimulus time and matched by an independent output monitor.
module tb_pll_phase_ctrl_dyn;
  localparam int NUM_OUT = 5;
  localparam int SEL_W = 3;
  localparam int STEP_W = 4;
  localparam int LOCK_WAIT = 16;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC = 8;
  localparam int STEP_PERIOD = PULSE_CYC + GAP_CYC;

  typedef struct {int start; int width; int sel; int dir;} pulse_t;
  typedef struct {int cyc; int err;} resp_t;

  // Initial step counts per output, as listed in the test plan (out1 = 3).
  int ref_init [NUM_OUT] = '{0, 3, 0, 0, 0};

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              pll_lock_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic [SEL_W-1:0]  req_sel_i = '0;
  logic              req_dir_i = 1'b0;
  logic [STEP_W-1:0] req_steps_i = '0;
  logic              req_ready_o, resp_valid_o, resp_err_o;
  logic [SEL_W-1:0]  phasesel_o;
  logic              phasedir_o, phasestep_o, phaseloadreg_o;
  logic              busy_o, lock_o, done_pll_init_o;

  pll_phase_ctrl_dyn #(
    .NUM_OUT(NUM_OUT), .SEL_W(SEL_W), .STEP_W(STEP_W),
    .INIT_STEPS(20'h00030), .INIT_EN(5'b11111),
    .LOCK_WAIT(LOCK_WAIT), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pll_lock_i(pll_lock_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_sel_i(req_sel_i), .req_dir_i(req_dir_i), .req_steps_i(req_steps_i),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o),
    .phasesel_o(phasesel_o), .phasedir_o(phasedir_o),
    .phasestep_o(phasestep_o), .phaseloadreg_o(phaseloadreg_o),
    .busy_o(busy_o), .lock_o(lock_o), .done_pll_init_o(done_pll_init_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  pulse_t exp_pulses[$];
  resp_t  exp_resps[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  logic in_pulse = 1'b0;
  int   p_start, p_width, p_sel, p_dir, p_bad;

  always @(negedge clk_i) begin
    pulse_t ep;
    resp_t  er;
    if (phasestep_o === 1'b1) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        p_start = cyc; p_width = 1; p_sel = int'(phasesel_o); p_dir = int'(phasedir_o);
        p_bad = busy_o ? 0 : 1;
      end else begin
        p_width++;
        if (int'(phasesel_o) != p_sel || int'(phasedir_o) != p_dir || !busy_o) p_bad = 1;
      end
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      if (exp_pulses.size() == 0) begin
        check("unexpected pulse start", p_start, -1);
      end else begin
        ep = exp_pulses.pop_front();
        check("pulse start", p_start, ep.start);
        check("pulse width", p_width, ep.width);
        check("pulse sel", p_sel, ep.sel);
        check("pulse dir", p_dir, ep.dir);
        check("pulse sel/dir stable, busy", p_bad, 0);
      end
    end
    if (resp_valid_o === 1'b1) begin
      if (exp_resps.size() == 0) begin
        check("unexpected resp cycle", cyc, -1);
      end else begin
        er = exp_resps.pop_front();
        check("resp cycle", cyc, er.cyc);
        check("resp err", int'(resp_err_o), er.err);
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_init(input int start, output int done_cyc);
    int c = start;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (ref_init[k] > 0) begin
        for (int j = 0; j < ref_init[k]; j++)
          exp_pulses.push_back('{c + 2 + j*STEP_PERIOD, PULSE_CYC, k, 0});
        c = c + 2 + ref_init[k]*STEP_PERIOD;
      end else if (k != NUM_OUT-1) begin
        c = c + 1;
      end
    end
    done_cyc = c + 1;
  endtask

  // cut < 0: runs to completion; otherwise the cycle lock drops / reset is applied.
  task automatic push_req(input int t, input int sel, input int dir, input int steps,
                          input int cut, input bit cut_is_reset);
    int s, w, last;
    if (sel >= NUM_OUT) begin
      exp_resps.push_back('{t + 1, 1});
    end else if (steps == 0) begin
      exp_resps.push_back('{t + 1, 0});
    end else begin
      last = (cut < 0) ? 32'h7fff_ffff : cut;
      for (int j = 0; j < steps; j++) begin
        s = t + 2 + j*STEP_PERIOD;
        if (s <= last) begin
          w = (last + 1 - s < PULSE_CYC) ? last + 1 - s : PULSE_CYC;
          exp_pulses.push_back('{s, w, sel, dir});
        end
      end
      if (cut < 0) exp_resps.push_back('{t + 2 + steps*STEP_PERIOD, 0});
      else if (!cut_is_reset) exp_resps.push_back('{cut + 1, 1});
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick_to(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_req(input int sel, input int dir, input int steps,
                        input int cut_off, input bit cut_is_reset, output int t);
    int budget = 0;
    @(negedge clk_i);
    while (!req_ready_o && budget < 3000) begin
      @(negedge clk_i);
      budget++;
    end
    if (!req_ready_o) check("ready wait timeout", 0, 1);
    req_valid_i = 1'b1;
    req_sel_i   = SEL_W'(sel);
    req_dir_i   = dir[0];
    req_steps_i = STEP_W'(steps);
    t = cyc;
    push_req(t, sel, dir, steps, (cut_off < 0) ? -1 : t + cut_off, cut_is_reset);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_sel_i   = SEL_W'($urandom);
    req_dir_i   = 1'($urandom);
    req_steps_i = STEP_W'($urandom);
  endtask

  task automatic wait_done(input string nm, input int exp_c);
    int budget = 0;
    @(negedge clk_i);
    while (!done_pll_init_o && budget < 3000) begin
      @(negedge clk_i);
      budget++;
    end
    if (!done_pll_init_o) check({nm, " timeout"}, 0, 1);
    else begin
      check(nm, cyc, exp_c);
      check({nm, " lock_o"}, int'(lock_o), 1);
    end
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_resps.size() > 0 || exp_pulses.size() > 0) && budget < 3000) begin
      @(negedge clk_i);
      budget++;
    end
    repeat (4) @(negedge clk_i);
    check("pending pulses", exp_pulses.size(), 0);
    check("pending resps", exp_resps.size(), 0);
  endtask

  task automatic check_zero(input string nm);
    check(nm, int'({phasestep_o, busy_o, done_pll_init_o, lock_o, req_ready_o,
                    resp_valid_o, resp_err_o, phaseloadreg_o, phasedir_o, phasesel_o}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, dc, bad;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_zero("reset outputs");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Power-up lock with a one-cycle glitch: the wait must restart at cycle 21.
    tick_to(10); pll_lock_i = 1'b1;
    tick_to(20); pll_lock_i = 1'b0;
    @(negedge clk_i);
    check("busy while waiting lock", int'(busy_o), 0);
    tick_to(21); pll_lock_i = 1'b1;
    push_init(21 + LOCK_WAIT, dc);
    wait_done("init done cycle", dc);

    // Directed request sel=2 dir=1 steps=3.
    do_req(2, 1, 3, -1, 1'b0, t);
    bad = 0;
    for (int c = t + 1; c <= t + 37; c++) begin
      @(negedge clk_i);
      if (req_ready_o) bad++;
    end
    check("ready low while busy", bad, 0);
    @(negedge clk_i);
    check("ready at completion", int'(req_ready_o), 1);

    do_req(6, 0, 5, -1, 1'b0, t);
    do_req(1, 1, 0, -1, 1'b0, t);
    drain();

    // Randomized requests, with occasional valid presented while not ready.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk_i);
        if (!req_ready_o) begin
          req_valid_i = 1'b1;
          req_sel_i   = SEL_W'($urandom);
          req_steps_i = STEP_W'($urandom_range(1, 15));
          @(posedge clk_i);
          #1;
          req_valid_i = 1'b0;
        end
      end
      do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 6)), -1, 1'b0, t);
    end
    drain();

    // Lock loss during the second pulse of a request.
    do_req(3, 1, 4, 15, 1'b0, t);
    tick_to(t + 15);
    pll_lock_i = 1'b0;
    @(negedge clk_i);
    check("lock_o falls with raw lock", int'(lock_o), 0);
    check("done held in drop cycle", int'(done_pll_init_o), 1);
    @(negedge clk_i);
    check("step low after lock loss", int'(phasestep_o), 0);
    check("done cleared after lock loss", int'(done_pll_init_o), 0);
    tick_to(t + 21);
    pll_lock_i = 1'b1;
    push_init(t + 21 + LOCK_WAIT, dc);
    wait_done("re-init done cycle", dc);
    drain();

    // Reset during the first pulse of a request.
    do_req(4, 0, 2, 3, 1'b1, t);
    tick_to(t + 3);
    rst_i = 1'b1;
    tick_to(t + 4);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_zero("reset mid-pulse outputs");
    push_init(t + 4 + LOCK_WAIT, dc);
    wait_done("post-reset init done cycle", dc);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pll_phase_ctrl_dyn.md
Name: pll_phase_ctrl_dyn

Overview:
- Parametrised dynamic-phase controller for a PLL with up to 8 outputs; successor to the fixed 5-output init-only phase sequencer.
- After PLL lock it applies per-output initial phase step counts, then serves runtime phase-adjust requests through a valid/ready handshake.
- Re-initialises automatically on loss of lock.
- Sits between the PLL primitive wrapper and user logic; drives the PLL dynamic phase port and a qualified lock / init-done pair.

Parameters:
- NUM_OUT, 5, number of PLL outputs under control (1..8).
- SEL_W, 3, width of phasesel_o and req_sel_i.
- STEP_W, 4, width of each step count.
- INIT_STEPS, 0, packed NUM_OUT*STEP_W initial step counts; output k uses bits [k*STEP_W +: STEP_W].
- INIT_EN, all ones, NUM_OUT-bit mask; output k is initialised only if bit k is set.
- LOCK_WAIT, 16, consecutive cycles pll_lock_i must be high before init starts (at least 1).
- PULSE_CYC, 4, cycles phasestep_o is held high per step (at least 1).
- GAP_CYC, 8, low cycles after each step pulse (at least 1).

Ports:
- clk_i  in  1  reference clock, same clock as the PLL input.
- rst_i  in  1  synchronous reset, active-high.
- pll_lock_i  in  1  raw PLL lock.
- req_valid_i  in  1  runtime adjust request.
- req_ready_o  out  1  controller can accept a request.
- req_sel_i  in  SEL_W  output index.
- req_dir_i  in  1  0 = delay, 1 = advance.
- req_steps_i  in  STEP_W  number of steps.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_err_o  out  1  qualifies resp_valid_o: request rejected or aborted.
- phasesel_o  out  SEL_W  PLL phase select.
- phasedir_o  out  1  PLL phase direction.
- phasestep_o  out  1  PLL phase step pulse.
- phaseloadreg_o  out  1  PLL load-register strobe; constant 0.
- busy_o  out  1  init or request in progress.
- lock_o  out  1  qualified lock = pll_lock_i & done_pll_init_o.
- done_pll_init_o  out  1  initial phases applied.

Behaviour:
- Reset values: all outputs 0; state WAIT_LOCK; all counters cleared.
- Reset applied mid-operation aborts immediately; no resp_valid_o is generated.
- States: WAIT_LOCK, INIT_NEXT, SETUP, PULSE, GAP, IDLE.
- WAIT_LOCK:
  - lock counter increments while pll_lock_i=1 and clears when it is 0.
  - On reaching LOCK_WAIT, go to INIT_NEXT with init index 0.
- INIT_NEXT:
  - Skip each output whose INIT_EN bit is 0 or whose INIT_STEPS count is 0, one index per cycle.
  - For the first output that needs steps, load its count, set dir=0 and sel=index, then go to SETUP.
  - After index NUM_OUT-1 (or when nothing remains), go to IDLE and set done_pll_init_o=1.
- SETUP:
  - One cycle; phasesel_o and phasedir_o are driven and phasestep_o is 0.
  - Next state is PULSE.
- PULSE:
  - phasestep_o=1 for PULSE_CYC cycles, then go to GAP.
- GAP:
  - phasestep_o=0 for GAP_CYC cycles.
  - Then decrement the remaining step count. If steps remain, return to PULSE; otherwise return to INIT_NEXT (init phase) or IDLE (request phase).
- phasesel_o and phasedir_o stay stable from SETUP through the final GAP cycle.
- busy_o = 1 in every state except IDLE and WAIT_LOCK.
- req_ready_o = 1 only in IDLE with done_pll_init_o=1. Acceptance is req_valid_i & req_ready_o; sel, dir and steps are captured on that edge.
- Request handling:
  - sel < NUM_OUT and steps > 0: go to SETUP on the next cycle.
  - sel >= NUM_OUT: no pulses; the next cycle gives resp_valid_o=1 and resp_err_o=1.
  - steps = 0: no pulses; the next cycle gives resp_valid_o=1 and resp_err_o=0.
- Completion: resp_valid_o pulses for one cycle on entry to IDLE after the last GAP cycle; req_ready_o is high in that same cycle.
- Request timing, accept edge T, steps n:
  - SETUP at T+1.
  - Step k is high during T+2+k*(PULSE_CYC+GAP_CYC) .. +PULSE_CYC-1.
  - resp_valid_o at T+2+n*(PULSE_CYC+GAP_CYC).
- Lock loss (pll_lock_i=0 in any state after WAIT_LOCK):
  - Next cycle: phasestep_o=0 and done_pll_init_o=0, then go to WAIT_LOCK.
  - An in-flight request completes with resp_valid_o=1 and resp_err_o=1 in that cycle.
  - Full init is re-run after re-lock.
- lock_o is combinational AND of pll_lock_i with the registered done flag, so it falls in the same cycle pll_lock_i falls.
- Arithmetic: all counters are unsigned and saturate-free; the step counter never underflows because 0 is never loaded into PULSE.

Test Plan:
- Lock and init: NUM_OUT=5, INIT_STEPS={0,0,0,3,0} (out1=3), LOCK_WAIT=16, PULSE_CYC=4, GAP_CYC=8; lock rises at cycle 10 -> exactly 3 phasestep pulses with phasesel=1, dir=0, each 4 cycles high / 8 low; then done_pll_init_o=1 and lock_o=1.
- Lock glitch during wait: lock high 10 cycles, low 1 cycle, then high -> the counter restarts and init begins 16 cycles after the re-rise.
- Runtime request: sel=2, dir=1, steps=3 accepted at T -> pulses start at T+2, T+14, T+26; resp_valid_o=1 with err=0 at T+38; req_ready_o=0 during T+1..T+37.
- Bad sel / zero steps: sel=6 with NUM_OUT=5 -> resp err=1 at T+1 with no pulses; steps=0 -> resp err=0 at T+1 with no pulses.
- Lock loss mid-request: drop pll_lock_i during the 2nd pulse -> next cycle phasestep_o=0, resp_valid_o=1, resp_err_o=1, done_pll_init_o=0; after re-lock plus 16 cycles, init is replayed.
- Reset mid-pulse: assert rst_i while phasestep_o=1 -> all outputs 0 on the next edge and no resp_valid_o.
